// File: rtl/pixel_readout_pkg.sv
// Shared types and sizing helpers for the pixel readout scheduler.
//   state_t            : readout FSM states
//   calc_words()       : bus words per frame (WIDTH*HEIGHT/pixels per word)
//   calc_index_width() : width of the word index, never less than 1 bit
package pixel_readout_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StSel,
        StSettle,
        StPresent,
        StDone
    } state_t;

    function automatic int unsigned calc_words(input int unsigned width,
                                               input int unsigned height,
                                               input int unsigned pix_per_word);
        return (width * height) / pix_per_word;
    endfunction

    function automatic int unsigned calc_index_width(input int unsigned width,
                                                     input int unsigned height,
                                                     input int unsigned pix_per_word);
        int unsigned words;
        words = calc_words(width, height, pix_per_word);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/pixel_readout_scheduler_counter.sv
// readout_word_counter: word index counter and settle down-counter.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   word_clear_i     : force the word index to 0 (wins over increment)
//   word_inc_i       : advance to the next word; holds at WORDS-1
//   word_index_o     : current word index (registered)
//   word_last_o      : word index is WORDS-1
//   settle_load_i    : load SETTLE_CYCLES into the settle counter
//   settle_en_i      : count the settle counter down
//   settle_last_o    : settle counter is on its final cycle
module readout_word_counter
    import pixel_readout_pkg::*;
#(
    parameter int unsigned WORDS         = 1000,
    parameter int unsigned IDX_W         = 10,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             word_clear_i,
    input  logic             word_inc_i,
    output logic [IDX_W-1:0] word_index_o,
    output logic             word_last_o,
    input  logic             settle_load_i,
    input  logic             settle_en_i,
    output logic             settle_last_o
);

    logic [IDX_W-1:0] word_d, word_q;
    logic [CNT_W-1:0] settle_d, settle_q;

    assign word_index_o  = word_q;
    assign word_last_o   = (word_q == IDX_W'(WORDS - 1));
    assign settle_last_o = (settle_q == CNT_W'(1));

    always_comb begin
        word_d = word_q;
        if (word_clear_i) begin
            word_d = '0;
        end else if (word_inc_i && !word_last_o) begin
            // Saturate at the last word so the index never wraps mid-frame
            word_d = word_q + IDX_W'(1);
        end
    end

    always_comb begin
        settle_d = settle_q;
        if (settle_load_i) begin
            settle_d = CNT_W'(SETTLE_CYCLES);
        end else if (settle_en_i && (settle_q != '0)) begin
            settle_d = settle_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q   <= '0;
            settle_q <= '0;
        end else begin
            word_q   <= word_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/pixel_readout_scheduler.sv
// Frame readout sequencer: strobes the pixel array read bus word by word,
// waits SETTLE_CYCLES per word, captures the bus and hands it downstream
// with a valid/ready handshake.
//   SYSTEM_CLK, SYSTEM_RESET : clock, asynchronous active-low reset
//   START, ABORT             : frame request, synchronous abort
//   DATA_IN, DATA_READY      : array read bus, downstream ready
//   READ_RESET, READ_CLK_IN  : array read-bus reset and word-select strobes
//   DATA_OUT, DATA_VALID     : held word and its valid flag
//   WORD_INDEX               : index of the word being read/presented
//   BUSY, FRAME_DONE         : not idle, end-of-frame pulse
//   OVERRUN                  : sticky, START seen while busy
module pixel_readout_scheduler
    import pixel_readout_pkg::*;
#(
    parameter int unsigned WIDTH                  = 100,
    parameter int unsigned HEIGHT                 = 100,
    parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 10,
    parameter int unsigned BIT_DEPTH              = 10,
    parameter int unsigned SETTLE_CYCLES          = 2
) (
    input  logic SYSTEM_CLK,
    input  logic SYSTEM_RESET,
    input  logic START,
    input  logic ABORT,
    input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_IN,
    input  logic DATA_READY,
    output logic READ_RESET,
    output logic READ_CLK_IN,
    output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_OUT,
    output logic DATA_VALID,
    output logic [calc_index_width(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH)-1:0] WORD_INDEX,
    output logic BUSY,
    output logic FRAME_DONE,
    output logic OVERRUN
);

    localparam int unsigned WORDS = calc_words(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH);
    localparam int unsigned IDX_W = calc_index_width(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    if ((WORDS * OUTPUT_BUS_PIXEL_WIDTH != WIDTH * HEIGHT) || (SETTLE_CYCLES < 1))
    begin : g_param_check
        $error("pixel_readout_scheduler: frame must split into whole words, SETTLE_CYCLES >= 1");
    end

    state_t state_q;

    logic word_clear, word_inc, word_last;
    logic settle_load, settle_en, settle_last;

    // Index returns to 0 on leaving DONE, or at once on abort
    assign word_clear  = ABORT || (state_q == StDone);
    assign word_inc    = (state_q == StPresent) && DATA_READY && !ABORT;
    assign settle_load = (state_q == StSel);
    assign settle_en   = (state_q == StSettle);

    readout_word_counter #(
        .WORDS        (WORDS),
        .IDX_W        (IDX_W),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_counter (
        .clk_i        (SYSTEM_CLK),
        .rst_ni       (SYSTEM_RESET),
        .word_clear_i (word_clear),
        .word_inc_i   (word_inc),
        .word_index_o (WORD_INDEX),
        .word_last_o  (word_last),
        .settle_load_i(settle_load),
        .settle_en_i  (settle_en),
        .settle_last_o(settle_last)
    );

    // Outputs are registered together with the state they belong to, so each
    // transition sets the output values of the state being entered.
    always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
        if (!SYSTEM_RESET) begin
            state_q     <= StIdle;
            READ_RESET  <= 1'b0;
            READ_CLK_IN <= 1'b0;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            READ_RESET  <= 1'b0;
            READ_CLK_IN <= 1'b0;
            FRAME_DONE  <= 1'b0;
            if (ABORT) begin
                state_q    <= StIdle;
                DATA_VALID <= 1'b0;
                BUSY       <= 1'b0;
                OVERRUN    <= 1'b0;
            end else begin
                // DONE counts as busy, so a START there is dropped too
                if (START && (state_q != StIdle)) begin
                    OVERRUN <= 1'b1;
                end
                case (state_q)
                    StIdle: begin
                        if (START) begin
                            state_q    <= StRst;
                            READ_RESET <= 1'b1;
                            BUSY       <= 1'b1;
                        end
                    end
                    StRst: begin
                        state_q     <= StSel;
                        READ_CLK_IN <= 1'b1;
                    end
                    StSel: begin
                        state_q <= StSettle;
                    end
                    StSettle: begin
                        if (settle_last) begin
                            state_q    <= StPresent;
                            DATA_OUT   <= DATA_IN;
                            DATA_VALID <= 1'b1;
                        end
                    end
                    StPresent: begin
                        if (DATA_READY) begin
                            DATA_VALID <= 1'b0;
                            if (word_last) begin
                                state_q    <= StDone;
                                FRAME_DONE <= 1'b1;
                            end else begin
                                state_q     <= StSel;
                                READ_CLK_IN <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        BUSY    <= 1'b0;
                    end
                    default: begin
                        state_q    <= StIdle;
                        DATA_VALID <= 1'b0;
                        BUSY       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout_scheduler.sv
// Testbench for pixel_readout_scheduler: default-size instance plus a
// 2-word instance. A behavioural array drives DATA_IN from the selected word
// and the cycles elapsed since its select strobe, so early or late capture
// shows up as wrong data.
module tb_pixel_readout_scheduler;

    localparam int S         = 2;
    localparam int WORDS     = 1000;
    localparam int FRAME_CYC = 2 + WORDS * (2 + S);
    localparam int SS        = 1;
    localparam int SWORDS    = 2;
    localparam int SFRAME    = 2 + SWORDS * (2 + SS);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, data_ready = 1'b0;
    logic [99:0] data_in, data_out;
    logic        read_reset, read_clk_in, data_valid, busy, frame_done, overrun;
    logic [9:0]  word_index;

    logic        s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b1;
    logic [39:0] s_data_in, s_data_out;
    logic        s_read_reset, s_read_clk_in, s_data_valid, s_busy, s_frame_done, s_overrun;
    logic [0:0]  s_word_index;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_now = 0;
    int done_cnt = 0;

    int          exp_idx[$], got_idx[$], s_exp_idx[$], s_got_idx[$];
    logic [99:0] exp_dat[$], got_dat[$];
    logic [39:0] s_exp_dat[$], s_got_dat[$];

    always #5 clk = ~clk;

    pixel_readout_scheduler dut (
        .SYSTEM_CLK  (clk),
        .SYSTEM_RESET(rst_n),
        .START       (start),
        .ABORT       (abort),
        .DATA_IN     (data_in),
        .DATA_READY  (data_ready),
        .READ_RESET  (read_reset),
        .READ_CLK_IN (read_clk_in),
        .DATA_OUT    (data_out),
        .DATA_VALID  (data_valid),
        .WORD_INDEX  (word_index),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done),
        .OVERRUN     (overrun)
    );

    pixel_readout_scheduler #(
        .WIDTH(4), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(4), .BIT_DEPTH(10), .SETTLE_CYCLES(1)
    ) dut_small (
        .SYSTEM_CLK  (clk),
        .SYSTEM_RESET(rst_n),
        .START       (s_start),
        .ABORT       (s_abort),
        .DATA_IN     (s_data_in),
        .DATA_READY  (s_ready),
        .READ_RESET  (s_read_reset),
        .READ_CLK_IN (s_read_clk_in),
        .DATA_OUT    (s_data_out),
        .DATA_VALID  (s_data_valid),
        .WORD_INDEX  (s_word_index),
        .BUSY        (s_busy),
        .FRAME_DONE  (s_frame_done),
        .OVERRUN     (s_overrun)
    );

    // Bus word for a given word and age (cycles since its select strobe)
    function automatic logic [99:0] mk(input int w, input int age);
        logic [31:0] h;
        logic [15:0] w16;
        logic [7:0]  a8;
        h   = w * 32'h9E37_79B9 + 32'h1234_ABCD;
        w16 = w[15:0];
        a8  = age[7:0];
        return {36'hA_5C3F_0F0E, h, w16, a8, 8'hC3};
    endfunction

    function automatic logic [39:0] mk_small(input int w, input int age);
        logic [99:0] r;
        r = mk(w, age);
        return r[39:0];
    endfunction

    // Behavioural pixel arrays
    int a_ptr = 0, a_word = 0, a_age = 0;
    int b_ptr = 0, b_word = 0, b_age = 0;
    assign data_in   = mk(a_word, a_age);
    assign s_data_in = mk_small(b_word, b_age);

    always @(negedge clk) begin
        if (read_reset === 1'b1) a_ptr = 0;
        if (read_clk_in === 1'b1) begin
            a_word = a_ptr; a_ptr = a_ptr + 1; a_age = 0;
        end else if (a_age < 255) a_age = a_age + 1;
        if (s_read_reset === 1'b1) b_ptr = 0;
        if (s_read_clk_in === 1'b1) begin
            b_word = b_ptr; b_ptr = b_ptr + 1; b_age = 0;
        end else if (b_age < 255) b_age = b_age + 1;
    end

    // Monitor: record every completed handshake
    always @(negedge clk) begin
        if (data_valid === 1'b1 && data_ready && !abort && rst_n) begin
            got_idx.push_back(int'(word_index));
            got_dat.push_back(data_out);
        end
        if (s_data_valid === 1'b1 && s_ready && !s_abort && rst_n) begin
            s_got_idx.push_back(int'(s_word_index));
            s_got_dat.push_back(s_data_out);
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_now++;
    endtask

    task automatic flush();
        exp_idx.delete(); exp_dat.delete(); got_idx.delete(); got_dat.delete();
        done_cnt = 0;
    endtask

    task automatic push_frame();
        for (int k = 0; k < WORDS; k++) begin
            exp_idx.push_back(k);
            exp_dat.push_back(mk(k, S));
        end
    endtask

    // START high for one cycle; returns in cycle 1 (just after edge 0)
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(input int idx, input int limit, output bit ok);
        int n = 0;
        while (!(data_valid === 1'b1 && int'(word_index) == idx) && n < limit) begin
            tick(); n++;
        end
        ok = (data_valid === 1'b1 && int'(word_index) == idx);
    endtask

    task automatic run_until_done(input int limit, output int at);
        int n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            tick(); n++;
        end
        at = (frame_done === 1'b1) ? cyc_now : -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (read_reset !== 1'b0) begin n_fail++; $display("FAIL rst_read_reset: got %b want 0", read_reset); end
        n_checks++; if (read_clk_in !== 1'b0) begin n_fail++; $display("FAIL rst_read_clk: got %b want 0", read_clk_in); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL rst_data_out: got %h want 0", data_out); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", data_valid); end
        n_checks++; if (word_index !== 10'd0) begin n_fail++; $display("FAIL rst_index: got %0d want 0", word_index); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", frame_done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        n_checks++; if (s_data_out !== '0) begin n_fail++; $display("FAIL rst_s_data: got %h want 0", s_data_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        int t0, first_valid, done_cyc, ei, gi;
        logic [99:0] ed, gd;
        data_ready = 1'b1;
        flush(); push_frame();
        pulse_start();
        t0 = cyc_now; first_valid = -1;
        n_checks++; if (read_reset !== 1'b1) begin n_fail++; $display("FAIL full_read_reset_c1: got %b want 1", read_reset); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_c1: got %b want 1", busy); end
        while (frame_done !== 1'b1 && cyc_now - t0 < FRAME_CYC + 50) begin
            if (data_valid === 1'b1 && first_valid < 0) first_valid = cyc_now - t0 + 1;
            tick();
        end
        done_cyc = (frame_done === 1'b1) ? cyc_now - t0 + 1 : -1;
        n_checks++; if (first_valid != 3 + S) begin n_fail++; $display("FAIL full_first_valid: got %0d want %0d", first_valid, 3 + S); end
        n_checks++; if (done_cyc != FRAME_CYC) begin n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, FRAME_CYC); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy); end
        n_checks++; if (word_index !== 10'd0) begin n_fail++; $display("FAIL full_index_after: got %0d want 0", word_index); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
        n_checks++; if (got_idx.size() != WORDS) begin n_fail++; $display("FAIL full_count: got %0d want %0d", got_idx.size(), WORDS); end
        while (exp_idx.size() > 0 && got_idx.size() > 0) begin
            ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
            gi = got_idx.pop_front(); gd = got_dat.pop_front();
            n_checks++;
            if (gi != ei || gd !== ed) begin
                n_fail++; $display("FAIL full_word: got idx %0d data %h want idx %0d data %h", gi, gd, ei, ed);
            end
        end
    endtask

    task automatic test_stall();
        int t0, at, ei, gi;
        bit ok;
        logic [99:0] ed, gd;
        data_ready = 1'b1;
        flush(); push_frame();
        pulse_start();
        t0 = cyc_now;
        wait_word(3, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_reach_word3: got 0 want 1"); end
        data_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", data_valid); end
            n_checks++; if (word_index !== 10'd3) begin n_fail++; $display("FAIL stall_index: got %0d want 3", word_index); end
            n_checks++; if (data_out !== mk(3, S)) begin n_fail++; $display("FAIL stall_data: got %h want %h", data_out, mk(3, S)); end
            n_checks++; if (read_clk_in !== 1'b0) begin n_fail++; $display("FAIL stall_no_select: got %b want 0", read_clk_in); end
            tick();
        end
        data_ready = 1'b1;
        tick();
        n_checks++; if (read_clk_in !== 1'b1) begin n_fail++; $display("FAIL stall_next_select: got %b want 1", read_clk_in); end
        n_checks++; if (word_index !== 10'd4) begin n_fail++; $display("FAIL stall_next_index: got %0d want 4", word_index); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: got %b want 0", data_valid); end
        run_until_done(FRAME_CYC + 50, at);
        n_checks++; if (at - t0 + 1 != FRAME_CYC + 7) begin n_fail++; $display("FAIL stall_frame_len: got %0d want %0d", at - t0 + 1, FRAME_CYC + 7); end
        tick();
        n_checks++; if (got_idx.size() != WORDS) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", got_idx.size(), WORDS); end
        while (exp_idx.size() > 0 && got_idx.size() > 0) begin
            ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
            gi = got_idx.pop_front(); gd = got_dat.pop_front();
            n_checks++;
            if (gi != ei || gd !== ed) begin
                n_fail++; $display("FAIL stall_word: got idx %0d data %h want idx %0d data %h", gi, gd, ei, ed);
            end
        end
    endtask

    task automatic test_abort();
        int ei, gi, n;
        bit ok;
        logic [99:0] ed, gd;
        data_ready = 1'b1;
        flush(); push_frame();
        pulse_start();
        wait_word(500, 3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reach_word500: got 0 want 1"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (word_index !== 10'd0) begin n_fail++; $display("FAIL abort_index: got %0d want 0", word_index); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", data_valid); end
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        n_checks++; if (got_idx.size() != 500) begin n_fail++; $display("FAIL abort_count: got %0d want 500", got_idx.size()); end
        while (got_idx.size() > 0 && exp_idx.size() > 0) begin
            ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
            gi = got_idx.pop_front(); gd = got_dat.pop_front();
            n_checks++;
            if (gi != ei || gd !== ed) begin
                n_fail++; $display("FAIL abort_word: got idx %0d data %h want idx %0d data %h", gi, gd, ei, ed);
            end
        end
        // A fresh frame starts again from word 0
        flush();
        pulse_start();
        n = 0;
        while (data_valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (word_index !== 10'd0) begin n_fail++; $display("FAIL abort_restart_index: got %0d want 0", word_index); end
        n_checks++; if (data_out !== mk(0, S)) begin n_fail++; $display("FAIL abort_restart_data: got %h want %h", data_out, mk(0, S)); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        flush();
    endtask

    task automatic test_overrun();
        int t0, at, ei, gi;
        bit ok;
        logic [99:0] ed, gd;
        data_ready = 1'b1;
        flush(); push_frame();
        pulse_start();
        t0 = cyc_now;
        wait_word(10, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_reach_word10: got 0 want 1"); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b want 0", overrun); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b want 1", busy); end
        run_until_done(FRAME_CYC + 50, at);
        n_checks++; if (at - t0 + 1 != FRAME_CYC) begin n_fail++; $display("FAIL ovr_frame_len: got %0d want %0d", at - t0 + 1, FRAME_CYC); end
        // START in the DONE cycle must not launch a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_done_start_busy: got %b want 0", busy); end
        n_checks++; if (read_reset !== 1'b0) begin n_fail++; $display("FAIL ovr_done_start_rr: got %b want 0", read_reset); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        n_checks++; if (got_idx.size() != WORDS) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", got_idx.size(), WORDS); end
        while (exp_idx.size() > 0 && got_idx.size() > 0) begin
            ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
            gi = got_idx.pop_front(); gd = got_dat.pop_front();
            n_checks++;
            if (gi != ei || gd !== ed) begin
                n_fail++; $display("FAIL ovr_word: got idx %0d data %h want idx %0d data %h", gi, gd, ei, ed);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_abort_clear: got %b want 0", overrun); end
    endtask

    task automatic test_reset_mid();
        int t0, at, ei, gi;
        bit ok;
        logic [99:0] ed, gd;
        data_ready = 1'b1;
        flush();
        pulse_start();
        wait_word(2, 100, ok);
        tick(); tick();  // SEL then first SETTLE cycle of word 3
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", data_out); end
        n_checks++; if (word_index !== 10'd0) begin n_fail++; $display("FAIL mid_rst_index: got %0d want 0", word_index); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", data_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", frame_done); end
        #1;
        rst_n = 1'b1;
        tick();
        flush(); push_frame();
        pulse_start();
        t0 = cyc_now;
        run_until_done(FRAME_CYC + 50, at);
        n_checks++; if (at - t0 + 1 != FRAME_CYC) begin n_fail++; $display("FAIL mid_frame_len: got %0d want %0d", at - t0 + 1, FRAME_CYC); end
        tick();
        n_checks++; if (got_idx.size() != WORDS) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", got_idx.size(), WORDS); end
        while (exp_idx.size() > 0 && got_idx.size() > 0) begin
            ei = exp_idx.pop_front(); ed = exp_dat.pop_front();
            gi = got_idx.pop_front(); gd = got_dat.pop_front();
            n_checks++;
            if (gi != ei || gd !== ed) begin
                n_fail++; $display("FAIL mid_word: got idx %0d data %h want idx %0d data %h", gi, gd, ei, ed);
            end
        end
    endtask

    task automatic test_small();
        int t0, n, ei, gi;
        logic [39:0] ed, gd;
        s_exp_idx.delete(); s_exp_dat.delete(); s_got_idx.delete(); s_got_dat.delete();
        for (int k = 0; k < SWORDS; k++) begin
            s_exp_idx.push_back(k);
            s_exp_dat.push_back(mk_small(k, SS));
        end
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        t0 = cyc_now; n = 0;
        while (s_frame_done !== 1'b1 && n < 50) begin tick(); n++; end
        n_checks++; if (cyc_now - t0 + 1 != SFRAME || s_frame_done !== 1'b1) begin
            n_fail++; $display("FAIL small_frame_len: got %0d want %0d", cyc_now - t0 + 1, SFRAME);
        end
        tick();
        n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL small_busy_after: got %b want 0", s_busy); end
        n_checks++; if (s_got_idx.size() != SWORDS) begin n_fail++; $display("FAIL small_count: got %0d want %0d", s_got_idx.size(), SWORDS); end
        while (s_exp_idx.size() > 0 && s_got_idx.size() > 0) begin
            ei = s_exp_idx.pop_front(); ed = s_exp_dat.pop_front();
            gi = s_got_idx.pop_front(); gd = s_got_dat.pop_front();
            n_checks++;
            if (gi != ei || gd !== ed) begin
                n_fail++; $display("FAIL small_word: got idx %0d data %h want idx %0d data %h", gi, gd, ei, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
